interconnect_link_buffer: RTL
=============================

Name: interconnect_link_buffer

Overview:
- Parametrised, registered successor to the plain link connector.
- Joins an upstream link sender to a downstream link receiver, placing an independent DEPTH-entry elastic FIFO on every physical plane.
- Breaks the combinational req/ack path between routers, which enables timing closure on long inter-PE wires.
- Optional bypass mode degenerates the block to a pure wire connector.

Parameters:
- NUM_PLANES, TIA_NUM_PHYSICAL_PLANES, number of independent physical planes.
- TAG_WIDTH, TIA_TAG_WIDTH, tag bits per plane.
- WORD_WIDTH, TIA_WORD_WIDTH, data bits per plane.
- DEPTH, 2, FIFO entries per plane (>=1; non-power-of-two legal).
- BYPASS, 0, 1 = combinational pass-through, no storage.
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- input_reqs  input  NUM_PLANES  upstream req per plane.
- input_acks  output  NUM_PLANES  upstream ack per plane.
- input_tag_lines  input  NUM_PLANES*TAG_WIDTH  plane p at [p*TAG_WIDTH +: TAG_WIDTH].
- input_data_lines  input  NUM_PLANES*WORD_WIDTH  plane p at [p*WORD_WIDTH +: WORD_WIDTH].
- output_reqs  output  NUM_PLANES  downstream req per plane.
- output_acks  input  NUM_PLANES  downstream ack per plane.
- output_tag_lines  output  NUM_PLANES*TAG_WIDTH  head-entry tag per plane.
- output_data_lines  output  NUM_PLANES*WORD_WIDTH  head-entry data per plane.
- occupancies  output  NUM_PLANES*CW  per-plane entry count.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Handshake: a transfer on a link occurs in any cycle where req && ack are both high at the rising edge. Senders hold tag/data stable while req is high. Planes are fully independent; no cross-plane ordering.
- Reset (BYPASS=0): while reset is high, all of the following are 0 in the same cycle and the next: output_reqs, input_acks, occupancies, and the head/tail pointers. FIFO storage is not reset. First cycle after reset deasserts: input_acks = all ones.
- input_acks[p] = (count[p] != DEPTH) && !reset. It is derived from registered state only; there is no combinational path from output_acks.
- output_reqs[p] = (count[p] != 0). It is registered-derived, with no combinational path from input_reqs.
- Output lines: head entry when count != 0; all zeros when empty (deterministic).
- Push: input_reqs[p] && input_acks[p] writes the entry at tail; tail wraps DEPTH-1 -> 0.
- Pop: output_reqs[p] && output_acks[p] advances head; head wraps DEPTH-1 -> 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, both pointers advance.
- Latency: a word accepted at edge N is presented on output_reqs/lines in the cycle after edge N (1 cycle). There is no fall-through.
- Full: ack is low even if a pop occurs the same cycle (no pass-through when full). Ack rises the cycle after the pop.
- Empty: req is low; a same-cycle push is not forwarded.
- Throughput:
  - DEPTH>=2: sustains 1 word/cycle/plane under continuous req and ack.
  - DEPTH=1: at most 1 word every 2 cycles.
- Ordering: strict FIFO per plane; no drop, no duplication.
- Reset mid-operation: all buffered words are discarded and counts return to 0. Downstream sees output_reqs fall in the reset cycle. Upstream words offered during reset are not accepted.
- BYPASS=1: output_reqs = input_reqs, input_acks = output_acks, lines are passed through combinationally, occupancies = 0. clock and reset are unused.
- occupancies[p] equals count[p], with range 0..DEPTH.

Test Plan:
- Reset, DEPTH=2, NUM_PLANES=2: hold reset 3 cycles with input_reqs=2'b11 -> input_acks=0, output_reqs=0, occupancies=0; cycle after release input_acks=2'b11.
- Plane 0 single push of tag=1, data=0xA5A5 at edge N, output_acks=1 -> output_reqs[0]=1 with tag 1 / data 0xA5A5 for exactly one cycle after N; plane 1 output_reqs stays 0.
- Continuous stream of data 1..20, input_reqs=1, output_acks=1, DEPTH=2 -> 20 words out in order 1..20, one per cycle after a 1-cycle latency; occupancy constant at 1.
- Backpressure, DEPTH=3: output_acks=0, push 4 words -> input_acks falls after the 3rd accept and occupancy=3. Raise output_acks for 1 cycle -> word 1 popped and ack still low that cycle; next cycle ack=1 and word 4 is accepted. Drain order is 1,2,3,4; pointers wrap correctly.
- Reset asserted with occupancy=2 on plane 1 -> next cycle output_reqs[1]=0 and occupancy 0. After release, the first new word (0x77) emerges first, with no stale data.
- BYPASS=1 -> output_reqs/lines track input_reqs/lines and input_acks tracks output_acks within the same cycle, for random stimulus over 100 cycles.

Source files
------------

// File: rtl/interconnect_link_buffer.sv
// interconnect_link_buffer: registered link connector between an upstream
// link sender and a downstream link receiver. Every physical plane gets its
// own DEPTH-entry elastic FIFO so that neither req nor ack crosses the block
// combinationally. With BYPASS=1 the block collapses to plain wires.
module interconnect_link_buffer #(
    parameter int NUM_PLANES = 4,
    parameter int TAG_WIDTH  = 3,
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter bit BYPASS     = 1'b0,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PLANES-1:0]            input_reqs,
    output logic [NUM_PLANES-1:0]            input_acks,
    input  logic [NUM_PLANES*TAG_WIDTH-1:0]  input_tag_lines,
    input  logic [NUM_PLANES*WORD_WIDTH-1:0] input_data_lines,
    output logic [NUM_PLANES-1:0]            output_reqs,
    input  logic [NUM_PLANES-1:0]            output_acks,
    output logic [NUM_PLANES*TAG_WIDTH-1:0]  output_tag_lines,
    output logic [NUM_PLANES*WORD_WIDTH-1:0] output_data_lines,
    output logic [NUM_PLANES*CW-1:0]         occupancies
);

    // One stored entry is the tag concatenated above the data word.
    localparam int EW = TAG_WIDTH + WORD_WIDTH;
    // Pointer width; a single-entry FIFO still needs a 1-bit pointer.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (BYPASS) begin : g_bypass
        assign output_reqs       = input_reqs;
        assign input_acks        = output_acks;
        assign output_tag_lines  = input_tag_lines;
        assign output_data_lines = input_data_lines;
        assign occupancies       = {(NUM_PLANES*CW){1'b0}};

        // Clock and reset have no function without storage.
        logic bypass_unused_s;
        assign bypass_unused_s = clock ^ reset;
    end else begin : g_buffer
        for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;
            logic [PW-1:0] head_q;
            logic [PW-1:0] head_d;
            logic [PW-1:0] tail_q;
            logic [PW-1:0] tail_d;
            logic [EW-1:0] mem_q [DEPTH];
            logic          in_ack_s;
            logic          out_req_s;
            logic          push_s;
            logic          pop_s;
            logic [EW-1:0] wr_entry_s;
            logic [EW-1:0] out_entry_s;

            // Handshake qualifiers come only from registered occupancy and reset,
            // so no req/ack path runs through the block; a full FIFO refuses
            // a push even when a pop happens in the same cycle.
            always_comb begin
                in_ack_s   = (count_q != CW'(DEPTH)) && !reset;
                out_req_s  = (count_q != {CW{1'b0}}) && !reset;
                push_s     = input_reqs[p] && in_ack_s;
                pop_s      = out_req_s && output_acks[p];
                wr_entry_s = {input_tag_lines[p*TAG_WIDTH +: TAG_WIDTH],
                              input_data_lines[p*WORD_WIDTH +: WORD_WIDTH]};
            end

            // Next occupancy and pointer values; pointers wrap at DEPTH-1 so
            // non-power-of-two depths work.
            always_comb begin
                count_d = count_q;
                head_d  = head_q;
                tail_d  = tail_q;
                if (push_s && !pop_s) begin
                    count_d = count_q + CW'(1);
                end else if (pop_s && !push_s) begin
                    count_d = count_q - CW'(1);
                end else begin
                    count_d = count_q;
                end
                if (push_s) begin
                    tail_d = (tail_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : tail_q + PW'(1);
                end else begin
                    tail_d = tail_q;
                end
                if (pop_s) begin
                    head_d = (head_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : head_q + PW'(1);
                end else begin
                    head_d = head_q;
                end
            end

            // Occupancy and pointer registers, cleared by the synchronous reset.
            always_ff @(posedge clock) begin
                if (reset) begin
                    count_q <= {CW{1'b0}};
                    head_q  <= {PW{1'b0}};
                    tail_q  <= {PW{1'b0}};
                end else begin
                    count_q <= count_d;
                    head_q  <= head_d;
                    tail_q  <= tail_d;
                end
            end

            // Entry storage; contents are qualified by count, so no reset needed.
            always_ff @(posedge clock) begin
                if (push_s) begin
                    mem_q[tail_q] <= wr_entry_s;
                end
            end

            // Present the head entry, or zeros when empty so idle lines are deterministic.
            always_comb begin
                out_entry_s = {EW{1'b0}};
                if (out_req_s) begin
                    out_entry_s = mem_q[head_q];
                end else begin
                    out_entry_s = {EW{1'b0}};
                end
            end

            assign input_acks[p]                                = in_ack_s;
            assign output_reqs[p]                               = out_req_s;
            assign output_tag_lines[p*TAG_WIDTH +: TAG_WIDTH]   = out_entry_s[EW-1 -: TAG_WIDTH];
            assign output_data_lines[p*WORD_WIDTH +: WORD_WIDTH] = out_entry_s[WORD_WIDTH-1:0];
            assign occupancies[p*CW +: CW]                      = reset ? {CW{1'b0}} : count_q;
        end
    end

endmodule
